// File: rtl/grid_cursor.sv
// Grid selection cursor: steps a (row, col) position from direction buttons with
// press-edge detection, hold-to-repeat and wrap/clamp edges; hands off selections via valid/ready.
module grid_cursor #(
  parameter int ROWS         = 6,
  parameter int COLS         = 6,
  parameter int WRAP         = 1,
  parameter int INIT_ROW     = 0,
  parameter int INIT_COL     = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int N  = ROWS * COLS,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          sel,
  input  logic          lock,
  output logic [N-1:0]  cur_bus,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          moved,
  output logic          sel_valid,
  output logic [IW-1:0] sel_idx,
  input  logic          sel_ready
);

  localparam int CNTW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY + 1) : 1;

  localparam logic [RW-1:0]   ROW_MAX    = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_MAX    = CW'(COLS - 1);
  localparam logic [RW-1:0]   ROW_INIT   = RW'(INIT_ROW);
  localparam logic [CW-1:0]   COL_INIT   = CW'(INIT_COL);
  localparam logic [RW-1:0]   ROW_ONE    = RW'(1);
  localparam logic [CW-1:0]   COL_ONE    = CW'(1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  // The counter value one cycle before the tick; reloading leaves REPEAT_RATE cycles to the next tick.
  localparam logic [CNTW-1:0] CNT_TOP    = CNTW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - REPEAT_RATE : 0);

  logic [3:0]      d;
  logic [3:0]      d_prev_reg;
  logic            sel_prev_reg;
  logic [RW-1:0]   row_reg, row_next;
  logic [CW-1:0]   col_reg, col_next;
  logic            moved_reg, moved_next;
  logic            sel_valid_reg, sel_valid_next;
  logic [IW-1:0]   sel_idx_reg, sel_idx_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0]   cur_idx;
  logic            new_press, hold_same, rep_tick, step;

  assign d       = {up, down, left, right};
  assign cur_idx = IW'(row_reg) * IW'(COLS) + IW'(col_reg);

  always_comb begin
    new_press      = |(d & ~d_prev_reg);
    hold_same      = (d == d_prev_reg) && (d != 4'b0000) && !lock;
    rep_tick       = 1'b0;
    cnt_next       = '0;
    row_next       = row_reg;
    col_next       = col_reg;
    sel_valid_next = sel_valid_reg;
    sel_idx_next   = sel_idx_reg;

    if (REPEAT_DELAY != 0 && hold_same) begin
      if (cnt_reg == CNT_TOP) begin
        rep_tick = 1'b1;
        cnt_next = CNT_RELOAD;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end

    step = !lock && (new_press || rep_tick);

    if (step) begin
      if (up && !down) begin
        if (row_reg == '0) row_next = (WRAP != 0) ? ROW_MAX : row_reg;
        else               row_next = row_reg - ROW_ONE;
      end else if (down && !up) begin
        if (row_reg == ROW_MAX) row_next = (WRAP != 0) ? '0 : row_reg;
        else                    row_next = row_reg + ROW_ONE;
      end
      if (left && !right) begin
        if (col_reg == '0) col_next = (WRAP != 0) ? COL_MAX : col_reg;
        else               col_next = col_reg - COL_ONE;
      end else if (right && !left) begin
        if (col_reg == COL_MAX) col_next = (WRAP != 0) ? '0 : col_reg;
        else                    col_next = col_reg + COL_ONE;
      end
    end

    moved_next = (row_next != row_reg) || (col_next != col_reg);

    // While an index is pending, the only thing that can happen is its acceptance.
    if (sel_valid_reg) begin
      if (sel_ready) sel_valid_next = 1'b0;
    end else if (sel && !sel_prev_reg && !lock) begin
      sel_valid_next = 1'b1;
      sel_idx_next   = cur_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev_reg    <= 4'b0000;
      sel_prev_reg  <= 1'b0;
      row_reg       <= ROW_INIT;
      col_reg       <= COL_INIT;
      moved_reg     <= 1'b0;
      sel_valid_reg <= 1'b0;
      sel_idx_reg   <= '0;
      cnt_reg       <= '0;
    end else begin
      d_prev_reg    <= d;
      sel_prev_reg  <= sel;
      row_reg       <= row_next;
      col_reg       <= col_next;
      moved_reg     <= moved_next;
      sel_valid_reg <= sel_valid_next;
      sel_idx_reg   <= sel_idx_next;
      cnt_reg       <= cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bus
      assign cur_bus[gi] = (cur_idx == IW'(gi));
    end
  endgenerate

  assign cur_row   = row_reg;
  assign cur_col   = col_reg;
  assign moved     = moved_reg;
  assign sel_valid = sel_valid_reg;
  assign sel_idx   = sel_idx_reg;

endmodule

// File: tb/tb_grid_cursor.sv
// Bench for grid_cursor: three parameterisations share one stimulus stream and are checked
// each cycle against an age-based behavioural model, plus hand-computed pins.
module tb_grid_cursor;

  localparam int ROWS = 6;
  localparam int COLS = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic sel = 1'b0, lock = 1'b0, sel_ready = 1'b0;

  logic [35:0] bus_o [3];
  logic [2:0]  row_o [3];
  logic [2:0]  col_o [3];
  logic        mv_o  [3];
  logic        sv_o  [3];
  logic [5:0]  idx_o [3];

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  // Instance 0: wrap, short repeat; 1: clamp, repeat disabled; 2: all defaults.
  int P_WRAP [3] = '{1, 0, 1};
  int P_RD   [3] = '{10, 0, 25000000};
  int P_RR   [3] = '{4, 1, 5000000};

  int       m_row   [3] = '{0, 0, 0};
  int       m_col   [3] = '{0, 0, 0};
  int       m_age   [3] = '{0, 0, 0};
  int       m_idx   [3] = '{0, 0, 0};
  bit       m_mv    [3] = '{0, 0, 0};
  bit       m_sv    [3] = '{0, 0, 0};
  bit       m_sprev [3] = '{0, 0, 0};
  bit [3:0] m_dprev [3] = '{4'd0, 4'd0, 4'd0};

  grid_cursor #(.REPEAT_DELAY(10), .REPEAT_RATE(4)) dut_a (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .sel(sel), .lock(lock), .cur_bus(bus_o[0]), .cur_row(row_o[0]), .cur_col(col_o[0]),
    .moved(mv_o[0]), .sel_valid(sv_o[0]), .sel_idx(idx_o[0]), .sel_ready(sel_ready));

  grid_cursor #(.WRAP(0), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut_b (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .sel(sel), .lock(lock), .cur_bus(bus_o[1]), .cur_row(row_o[1]), .cur_col(col_o[1]),
    .moved(mv_o[1]), .sel_valid(sv_o[1]), .sel_idx(idx_o[1]), .sel_ready(sel_ready));

  grid_cursor dut_c (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .sel(sel), .lock(lock), .cur_bus(bus_o[2]), .cur_row(row_o[2]), .cur_col(col_o[2]),
    .moved(mv_o[2]), .sel_valid(sv_o[2]), .sel_idx(idx_o[2]), .sel_ready(sel_ready));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t got %0d want %0d", nm, k, $time, act, exp);
    end
  endtask

  // Model: age counts cycles since the current held combination began (or lock/release).
  task automatic model_step(input int k);
    bit [3:0] d;
    bit restart, rep, stp;
    int age_n, nr, nc;
    d = {up, down, left, right};
    if (rst) begin
      m_row[k] = 0; m_col[k] = 0; m_age[k] = 0; m_idx[k] = 0;
      m_mv[k] = 0; m_sv[k] = 0; m_sprev[k] = 0; m_dprev[k] = 4'd0;
      return;
    end
    restart = (d != m_dprev[k]) || (d == 4'd0) || lock;
    age_n   = restart ? 0 : m_age[k] + 1;
    rep     = !restart && (P_RD[k] != 0) &&
              ((age_n == P_RD[k]) || ((age_n > P_RD[k]) && ((age_n - P_RD[k]) % P_RR[k] == 0)));
    stp     = !lock && (((d & ~m_dprev[k]) != 4'd0) || rep);
    nr = m_row[k];
    nc = m_col[k];
    if (stp) begin
      if (up && !down)    nr = (m_row[k] == 0) ? (P_WRAP[k] != 0 ? ROWS - 1 : 0) : m_row[k] - 1;
      if (down && !up)    nr = (m_row[k] == ROWS - 1) ? (P_WRAP[k] != 0 ? 0 : ROWS - 1) : m_row[k] + 1;
      if (left && !right) nc = (m_col[k] == 0) ? (P_WRAP[k] != 0 ? COLS - 1 : 0) : m_col[k] - 1;
      if (right && !left) nc = (m_col[k] == COLS - 1) ? (P_WRAP[k] != 0 ? 0 : COLS - 1) : m_col[k] + 1;
    end
    if (m_sv[k]) begin
      if (sel_ready) m_sv[k] = 0;
    end else if (sel && !m_sprev[k] && !lock) begin
      m_sv[k]  = 1;
      m_idx[k] = m_row[k] * COLS + m_col[k];
    end
    m_mv[k]    = (nr != m_row[k]) || (nc != m_col[k]);
    m_row[k]   = nr;
    m_col[k]   = nc;
    m_age[k]   = age_n;
    m_dprev[k] = d;
    m_sprev[k] = sel;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  always @(negedge clk) begin
    logic [35:0] one;
    logic [35:0] eb;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        one = 36'd1;
        eb  = one << (m_row[k] * COLS + m_col[k]);
        chk("row", k, row_o[k], m_row[k]);
        chk("col", k, col_o[k], m_col[k]);
        chk("bus", k, bus_o[k], eb);
        chk("moved", k, mv_o[k], m_mv[k]);
        chk("sel_valid", k, sv_o[k], m_sv[k]);
        chk("sel_idx", k, idx_o[k], m_idx[k]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] dv);
    {up, down, left, right} = dv;
    step(1);
    {up, down, left, right} = 4'd0;
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    step(2);
    started = 1'b1;
    $display("reset: row=%0d col=%0d bus=%0h", row_o[0], col_o[0], bus_o[0]);
    chk("pin_rst_row", 0, row_o[0], 0);
    chk("pin_rst_bus", 0, bus_o[0], 1);
    chk("pin_rst_sv", 0, sv_o[0], 0);
    chk("pin_rst_idx", 0, idx_o[0], 0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      right = 1'b1; step(1);
      chk("pin_right_mv", 0, mv_o[0], 1);
      chk("pin_right_col", 0, col_o[0], i + 1);
      right = 1'b0; step(1);
      chk("pin_idle_mv", 0, mv_o[0], 0);
      $display("right pulse %0d: col=%0d", i, col_o[0]);
    end
    chk("pin_bus3", 0, bus_o[0], 36'h8);

    do_reset();
    up = 1'b1; step(1);
    chk("pin_wrap_up_row", 0, row_o[0], 5);
    chk("pin_wrap_up_bus", 0, bus_o[0], 36'h40000000);
    chk("pin_clamp_up_row", 1, row_o[1], 0);
    chk("pin_clamp_up_mv", 1, mv_o[1], 0);
    up = 1'b0; step(1);
    left = 1'b1; step(1);
    chk("pin_wrap_left_bus", 0, bus_o[0], 36'h800000000);
    chk("pin_clamp_left_col", 1, col_o[1], 0);
    chk("pin_clamp_left_mv", 1, mv_o[1], 0);
    left = 1'b0; step(1);
    {up, down, left, right} = 4'b0101; step(1);
    chk("pin_diag_bus", 1, bus_o[1], 36'h80);
    chk("pin_diag_wrap_bus", 0, bus_o[0], 36'h1);
    {up, down, left, right} = 4'd0; step(1);
    $display("edges: A=(%0d,%0d) B=(%0d,%0d)", row_o[0], col_o[0], row_o[1], col_o[1]);

    do_reset();
    press(4'b0001); press(4'b0001);
    down = 1'b1; step(30);
    chk("pin_hold_row", 0, row_o[0], 0);
    chk("pin_hold_col", 0, col_o[0], 2);
    chk("pin_norep_row", 1, row_o[1], 1);
    chk("pin_slowrep_row", 2, row_o[2], 1);
    down = 1'b0; step(2);
    $display("hold down 30: A=(%0d,%0d)", row_o[0], col_o[0]);

    do_reset();
    press(4'b0001); press(4'b0001);
    down = 1'b1; step(12);
    chk("pin_hold12_row", 0, row_o[0], 2);
    left = 1'b1; step(1);
    chk("pin_add_row", 0, row_o[0], 3);
    chk("pin_add_col", 0, col_o[0], 1);
    step(9);
    chk("pin_wait_row", 0, row_o[0], 3);
    step(1);
    chk("pin_rep2_row", 0, row_o[0], 4);
    chk("pin_rep2_col", 0, col_o[0], 0);
    down = 1'b0; left = 1'b0; step(2);
    $display("add left mid-hold: A=(%0d,%0d)", row_o[0], col_o[0]);

    do_reset();
    press(4'b0100); press(4'b0100);
    press(4'b0001); press(4'b0001); press(4'b0001);
    sel = 1'b1; step(1);
    chk("pin_sel_sv", 0, sv_o[0], 1);
    chk("pin_sel_idx", 0, idx_o[0], 15);
    sel = 1'b0; step(1);
    press(4'b0001);
    sel = 1'b1; step(1); sel = 1'b0; step(1);
    chk("pin_sel_hold_idx", 0, idx_o[0], 15);
    sel = 1'b1; sel_ready = 1'b1; step(1);
    chk("pin_accept_sv", 0, sv_o[0], 0);
    chk("pin_accept_idx", 0, idx_o[0], 15);
    sel = 1'b0; sel_ready = 1'b0; step(1);
    chk("pin_drop_sv", 0, sv_o[0], 0);
    sel = 1'b1; step(1);
    chk("pin_sel2_idx", 0, idx_o[0], 16);
    sel = 1'b0; sel_ready = 1'b1; step(1);
    sel_ready = 1'b0;
    $display("select: idx=%0d valid=%0d", idx_o[0], sv_o[0]);

    lock = 1'b1;
    right = 1'b1; step(1);
    chk("pin_lock_col", 0, col_o[0], 4);
    chk("pin_lock_mv", 0, mv_o[0], 0);
    right = 1'b0; sel = 1'b1; step(1);
    sel = 1'b0; step(1);
    chk("pin_lock_sv", 0, sv_o[0], 0);
    up = 1'b1; step(3);
    lock = 1'b0; step(1);
    chk("pin_unlock_row", 0, row_o[0], 2);
    up = 1'b0; step(1);
    $display("lock: A=(%0d,%0d) valid=%0d", row_o[0], col_o[0], sv_o[0]);

    sel = 1'b1; step(1); sel = 1'b0;
    down = 1'b1; step(12);
    chk("pin_prerst_row", 0, row_o[0], 4);
    chk("pin_prerst_sv", 0, sv_o[0], 1);
    rst = 1'b1; step(1);
    chk("pin_midrst_row", 0, row_o[0], 0);
    chk("pin_midrst_col", 0, col_o[0], 0);
    chk("pin_midrst_sv", 0, sv_o[0], 0);
    chk("pin_midrst_idx", 0, idx_o[0], 0);
    chk("pin_midrst_mv", 0, mv_o[0], 0);
    rst = 1'b0; step(1);
    chk("pin_heldrst_row", 0, row_o[0], 1);
    chk("pin_heldrst_mv", 0, mv_o[0], 1);
    down = 1'b0; step(2);
    $display("reset mid-repeat: A=(%0d,%0d)", row_o[0], col_o[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
